// File: rtl/conv1_out_serializer.sv
// Buffers conv1 result vectors in a small FIFO and streams them one lane word per cycle.
// Optional macro CONV1_SER_RELU_EN clamps negative lane words to zero on m_data.
module conv1_out_serializer #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 9,
  parameter int DEPTH    = 4,
  parameter int OUT_COLS = 26,
  parameter int OUT_ROWS = 34
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [LANES*DATA_W-1:0]   data_in,
  output logic                      ready_in,
  output logic                      overflow,
  output logic [DATA_W-1:0]         m_data,
  output logic [$clog2(LANES)-1:0]  m_lane,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_sof,
  output logic                      m_eol,
  output logic                      m_eof
);

  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int COL_W  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int ROW_W  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(OUT_ROWS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SEND
  } state_t;

  state_t state_reg, state_next;

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              m_valid_reg, m_valid_next;
  logic [DATA_W-1:0] m_data_reg;
  logic              overflow_reg;

  logic              push, drop, pop, hs, last_lane;
  logic              load_word;
  logic [PTR_W-1:0]  rd_addr;
  logic [LANE_W-1:0] rd_lane;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] lane_in [LANES];
  logic [DATA_W-1:0] mem [DEPTH][LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_unpack
      assign lane_in[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [DATA_W-1:0] out_xform(input logic [DATA_W-1:0] w);
`ifdef CONV1_SER_RELU_EN
    return w[DATA_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Fullness is judged on the registered count; a same-cycle pop never frees the slot.
  assign push      = valid_in && (count_reg < FULL_CNT);
  assign drop      = valid_in && (count_reg == FULL_CNT);
  assign hs        = m_valid_reg && m_ready;
  assign last_lane = (lane_reg == LAST_LANE);

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++) begin
        mem[wr_ptr_reg][i] <= lane_in[i];
      end
    end
  end

  assign rd_word = mem[rd_addr][rd_lane];

  always_comb begin
    state_next   = state_reg;
    m_valid_next = m_valid_reg;
    lane_next    = lane_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    load_word    = 1'b0;
    pop          = 1'b0;
    rd_addr      = rd_ptr_reg;
    rd_lane      = '0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = PRIME;
        end
      end
      PRIME: begin
        load_word    = 1'b1;
        m_valid_next = 1'b1;
        lane_next    = '0;
        state_next   = SEND;
      end
      SEND: begin
        if (hs) begin
          if (last_lane) begin
            pop       = 1'b1;
            lane_next = '0;
            if (col_reg == LAST_COL) begin
              col_next = '0;
              row_next = (row_reg == LAST_ROW) ? '0 : row_reg + ROW_W'(1);
            end else begin
              col_next = col_reg + COL_W'(1);
            end
            // The next vector is already resident, so lane 0 follows without a bubble.
            if (count_reg > CNT_W'(1)) begin
              load_word = 1'b1;
              rd_addr   = rd_ptr_reg + PTR_W'(1);
            end else begin
              m_valid_next = 1'b0;
              state_next   = IDLE;
            end
          end else begin
            load_word = 1'b1;
            lane_next = lane_reg + LANE_W'(1);
            rd_lane   = lane_reg + LANE_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      lane_reg     <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      lane_reg    <= lane_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
      m_valid_reg <= m_valid_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (load_word) begin
        m_data_reg <= out_xform(rd_word);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign ready_in = (count_reg < FULL_CNT);
  assign overflow = overflow_reg;
  assign m_data   = m_data_reg;
  assign m_lane   = lane_reg;
  assign m_valid  = m_valid_reg;

  // Flags qualify only a presented word, so they stay low while idle or in reset.
  assign m_sof = m_valid_reg && (lane_reg == '0) && (col_reg == '0) && (row_reg == '0);
  assign m_eol = m_valid_reg && last_lane && (col_reg == LAST_COL);
  assign m_eof = m_eol && (row_reg == LAST_ROW);

endmodule

// File: tb/tb_conv1_out_serializer.sv
// Scoreboard bench for conv1_out_serializer: random and directed vectors, reference model of
// FIFO occupancy and frame position driven from the accepted-vector count.
module tb_conv1_out_serializer;

  localparam int DATA_W   = 32;
  localparam int LANES    = 9;
  localparam int DEPTH    = 4;
  localparam int OUT_COLS = 26;
  localparam int OUT_ROWS = 34;
  localparam int FRAME_W  = OUT_COLS * OUT_ROWS * LANES;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     valid_in;
  logic [LANES*DATA_W-1:0]  data_in;
  logic                     ready_in;
  logic                     overflow;
  logic [DATA_W-1:0]        m_data;
  logic [$clog2(LANES)-1:0] m_lane;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_sof, m_eol, m_eof;

  always #5 clk = ~clk;

  conv1_out_serializer #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .OUT_COLS(OUT_COLS), .OUT_ROWS(OUT_ROWS)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .overflow(overflow), .m_data(m_data), .m_lane(m_lane), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                lane;
    bit                sof;
    bit                eol;
    bit                eof;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int occ, vec_idx;
  bit ovf_m;
  int words_seen = 0;
  int frame_words, sof_cnt, eol_cnt, eof_cnt, eof_at, last_sof_at;
  int mode = 0;

  logic [DATA_W-1:0] vec_buf [LANES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_out(input logic [DATA_W-1:0] w);
`ifdef CONV1_SER_RELU_EN
    if ($signed(w) < 0) return '0;
`endif
    return w;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] pack_vec();
    logic [LANES*DATA_W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) v[l*DATA_W +: DATA_W] = vec_buf[l];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec();
    data_in  = pack_vec();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic rand_vec();
    for (int l = 0; l < LANES; l++) vec_buf[l] = $urandom;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < bound) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < bound), 64'(1));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    tick();
    tick();
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_lane", 64'(m_lane), 64'(0));
    check("rst_flags", 64'({m_sof, m_eol, m_eof}), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_ready_in", 64'(ready_in), 64'(1));
    rst = 1'b0;
  endtask

  // Consumer ready generator: 0 always, 1 pattern 1,0,0,1, 2 random, 3 stalled.
  initial begin : ready_gen
    int ph;
    ph = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: m_ready = 1'b1;
        1: begin m_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    bit accept, held_v;
    logic [DATA_W-1:0] held_d;
    logic [$clog2(LANES)-1:0] held_l;
    int col, row;
    held_v = 1'b0;
    held_d = '0;
    held_l = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        occ     = 0;
        vec_idx = 0;
        ovf_m   = 1'b0;
        held_v  = 1'b0;
      end else begin
        check("overflow", 64'(overflow), 64'(ovf_m));
        check("ready_in", 64'(ready_in), 64'(occ < DEPTH));
        if (held_v) begin
          check("stall_valid", 64'(m_valid), 64'(1));
          check("stall_data", 64'(m_data), 64'(held_d));
          check("stall_lane", 64'(m_lane), 64'(held_l));
        end
        accept = valid_in && (occ < DEPTH);
        if (m_valid && m_ready) begin
          words_seen++;
          frame_words++;
          if (m_sof) begin sof_cnt++; last_sof_at = frame_words; end
          if (m_eol) eol_cnt++;
          if (m_eof) begin eof_cnt++; eof_at = frame_words; end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got data 0x%0h lane %0d, expected no word", m_data, m_lane);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 64'(m_data), 64'(e.data));
            check("word_lane", 64'(m_lane), 64'(e.lane));
            check("word_sof", 64'(m_sof), 64'(e.sof));
            check("word_eol", 64'(m_eol), 64'(e.eol));
            check("word_eof", 64'(m_eof), 64'(e.eof));
            if (e.lane == LANES - 1) occ--;
          end
        end
        if (accept) begin
          col = vec_idx % OUT_COLS;
          row = (vec_idx / OUT_COLS) % OUT_ROWS;
          for (int l = 0; l < LANES; l++) begin
            e.data = ref_out(data_in[l*DATA_W +: DATA_W]);
            e.lane = l;
            e.sof  = (l == 0) && (col == 0) && (row == 0);
            e.eol  = (l == LANES - 1) && (col == OUT_COLS - 1);
            e.eof  = e.eol && (row == OUT_ROWS - 1);
            exp_q.push_back(e);
          end
          vec_idx++;
          occ++;
        end else if (valid_in) begin
          ovf_m = 1'b1;
        end
        held_v = m_valid && !m_ready;
        held_d = m_data;
        held_l = m_lane;
      end
    end
  end

  initial begin : stimulus
    int n, w0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    mode     = 0;
    do_reset();

    // Single vector: first word two edges after the push edge.
    for (int l = 0; l < LANES; l++) vec_buf[l] = 32'h100 + 32'(l);
    drive_vec();
    check("lat_edge_n", 64'(m_valid), 64'(0));
    tick();
    check("lat_edge_n1", 64'(m_valid), 64'(0));
    tick();
    check("lat_edge_n2", 64'(m_valid), 64'(1));
    check("first_data", 64'(m_data), 64'(32'h100));
    check("first_sof", 64'(m_sof), 64'(1));
    wait_drain(50);
    tick();
    check("idle_after_vec", 64'(m_valid), 64'(0));

    // Back-pressure with a 1,0,0,1 ready pattern.
    mode = 1;
    drive_vec();
    wait_drain(100);

    // Overflow: five consecutive pushes into a stalled FIFO.
    mode = 3;
    tick();
    tick();
    w0 = words_seen;
    for (int k = 0; k < 5; k++) begin
      rand_vec();
      vec_buf[0] = 32'(k);
      data_in  = pack_vec();
      valid_in = 1'b1;
      tick();
      if (k == 3) check("full_after_4th", 64'(ready_in), 64'(0));
    end
    valid_in = 1'b0;
    tick();
    check("overflow_set", 64'(overflow), 64'(1));
    mode = 1;
    wait_drain(400);
    check("overflow_words", 64'(words_seen - w0), 64'(36));
    check("overflow_sticky", 64'(overflow), 64'(1));

    // Reset while lane 4 is presented and vectors are buffered.
    mode = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      rand_vec();
      data_in  = pack_vec();
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    n = 0;
    while (!(m_valid && m_lane == 4) && n < 30) begin
      tick();
      n++;
    end
    check("lane4_reached", 64'(n < 30), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_ready_in", 64'(ready_in), 64'(1));
    check("midrst_overflow", 64'(overflow), 64'(0));
    rand_vec();
    drive_vec();
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    check("restart_lane", 64'(m_lane), 64'(0));
    check("restart_sof", 64'(m_sof), 64'(1));
    wait_drain(50);

    // Full frame plus the first vector of the next frame.
    do_reset();
    frame_words = 0;
    sof_cnt     = 0;
    eol_cnt     = 0;
    eof_cnt     = 0;
    eof_at      = 0;
    last_sof_at = 0;
    for (int i = 0; i <= OUT_COLS * OUT_ROWS; i++) begin
      rand_vec();
      vec_buf[0] = 32'(i);
      drive_vec();
      repeat (8) tick();
    end
    wait_drain(100);
    check("frame_eol_count", 64'(eol_cnt), 64'(OUT_ROWS));
    check("frame_eof_count", 64'(eof_cnt), 64'(1));
    check("frame_eof_word", 64'(eof_at), 64'(FRAME_W));
    check("frame_sof_count", 64'(sof_cnt), 64'(2));
    check("frame_sof2_word", 64'(last_sof_at), 64'(FRAME_W + 1));

    // Random traffic with random back-pressure; overflow is tracked by the model.
    mode = 2;
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) begin
        rand_vec();
        data_in  = pack_vec();
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    valid_in = 1'b0;
    mode = 0;
    wait_drain(300);

    // Sign-boundary lane words.
    rand_vec();
    vec_buf[0] = 32'hFFFF_FFFF;
    vec_buf[1] = 32'h8000_0000;
    vec_buf[2] = 32'h0000_0005;
    drive_vec();
    wait_drain(50);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1_out_serializer.md
Name: conv1_out_serializer

Overview:
- Receiving end of the conv1_layer result interface: captures each parallel 9-lane result vector (`conv1_out[0:8]`, qualified by `valid_out`) into a small vector FIFO.
- Drains each vector one 32-bit word per cycle over a valid/ready stream, tagged with lane index and frame/row markers.
- Sits between conv1_layer and the next layer or the memory writer. Decouples conv1's unstoppable burst output from a back-pressured consumer.

Parameters:
- DATA_W, 32, width of one lane word.
- LANES, 9, lanes per result vector.
- DEPTH, 4, vector FIFO depth in vectors (power of 2, ≥2).
- OUT_COLS, 26, result vectors per output row.
- OUT_ROWS, 34, output rows per frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  result vector valid; driven from conv1 valid_out.
- data_in  in  LANES*DATA_W  packed vector, lane 0 at bits [DATA_W-1:0].
- ready_in  out  1  advisory: FIFO not full. conv1 ignores it.
- overflow  out  1  sticky: a vector was dropped.
- m_data  out  DATA_W  serialized lane word.
- m_lane  out  $clog2(LANES)  lane index of m_data.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts.
- m_sof  out  1  word is lane 0 of col 0, row 0.
- m_eol  out  1  word is last lane of last column of a row.
- m_eof  out  1  word is last lane of last column of last row.

Behaviour:
- Reset: rst sampled at posedge only. Effects:
  - Outputs: m_valid=0, m_data=0, m_lane=0, m_sof/m_eol/m_eof=0, overflow=0, ready_in=1.
  - Internal: FIFO pointers and count=0, lane/col/row counters=0, FSM=IDLE.
  - Reset mid-operation discards all buffered and in-flight data. There is no partial-frame recovery.
- Push:
  - When valid_in=1 and registered count<DEPTH, data_in is written at wr_ptr and wr_ptr wraps mod DEPTH.
  - When valid_in=1 and count==DEPTH, the vector is dropped and overflow sets (sticky until rst).
  - A same-cycle pop does not free a slot for that push: fullness is judged on the registered count.
- ready_in = (count<DEPTH), registered view.
- FSM states:
  - IDLE:
    - Loads the head vector when count>0.
    - Sets m_valid=1 the next cycle with lane 0. → SEND.
  - SEND:
    - m_data/m_lane/flags are held stable while m_valid=1 and m_ready=0.
    - On handshake (m_valid&m_ready), lane increments.
    - On handshake of lane LANES-1, the head is popped (rd_ptr++, count--).
    - If another vector is available, lane 0 of it is presented on the next cycle with no bubble. Otherwise m_valid=0 → IDLE.
- Simultaneous push and pop in one cycle: count unchanged. Both pointers advance.
- Latency:
  - A vector pushed at edge N with the FIFO empty and FSM in IDLE gives first word m_valid=1 after edge N+2.
  - Sustained throughput is 1 word/cycle, i.e. 1 vector per LANES cycles.
- Position counters:
  - col increments on the handshake of lane LANES-1.
  - col wraps OUT_COLS-1→0 and increments row. row wraps OUT_ROWS-1→0, which starts the next frame.
  - Dropped vectors do not advance counters.
- Flags are combinational from the registered lane/col/row of the presented word:
  - m_sof = lane==0 & col==0 & row==0.
  - m_eol = lane==LANES-1 & col==OUT_COLS-1.
  - m_eof = m_eol & row==OUT_ROWS-1.
- m_data is registered output, taken directly from the FIFO lane slice. No arithmetic unless the optional feature is enabled.

Optional Feature:
- Macro CONV1_SER_RELU_EN.
  - Defined: each lane word is treated as signed DATA_W. Negative values (MSB=1) are output as 0 on m_data. Applied in the output register stage, so latency is unchanged.
  - Undefined: m_data is a bit-exact copy of the lane word.

Test Plan:
- Single vector:
  - Stimulus: after reset, push one vector with lanes 0..8 = 32'h100+lane, m_ready=1.
  - Response: m_data 0x100..0x108 on 9 consecutive cycles, first word 2 cycles after the push edge, m_lane 0..8, m_sof=1 on the first word only, then m_valid=0.
- Back-pressure:
  - Stimulus: same vector; toggle m_ready 1,0,0,1,…
  - Response: m_data/m_lane held stable while stalled, all 9 words delivered in order with no duplicates.
- Overflow:
  - Stimulus: m_ready=0, push 5 vectors on consecutive cycles (DEPTH=4).
  - Response: ready_in=0 after the 4th, vector 5 dropped, overflow=1 and stays 1. After m_ready=1, exactly 36 words emerge (vectors 1-4).
- Full frame:
  - Stimulus: push 26×34 vectors with a vector index in lane 0, m_ready=1, one vector every 9 cycles.
  - Response: m_eol on every 234th word, m_eof on word 7956 only, m_sof on words 1 and 7957 (second frame).
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle while 3 vectors are buffered and lane 4 is presented.
  - Response: next cycle m_valid=0, ready_in=1, overflow=0. The next push restarts at lane 0 with m_sof=1.
- RELU (CONV1_SER_RELU_EN defined):
  - Stimulus: lane words 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005.
  - Response: m_data 0, 0, 5. With the macro undefined: 32'hFFFF_FFFF, 32'h8000_0000, 5.
